// File: rtl/scompliment_ctrl.sv
// Sequencer for the bit-serial two's-complement unit: request handshake, load pulse,
// WIDTH shift cycles, result capture and response handshake. Optional macro: SCOMP_OVF_DETECT_EN.
module scompliment_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             dp_load,
  output logic [WIDTH-1:0] dp_load_sig,
  input  logic [WIDTH-1:0] dp_out_sig
`ifdef SCOMP_OVF_DETECT_EN
  ,
  output logic             res_ovf
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  if (WIDTH < 2) begin : g_width_check
    $error("scompliment_ctrl: WIDTH must be at least 2");
  end

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShift,
    StCapt,
    StResp
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;

`ifdef SCOMP_OVF_DETECT_EN
  // The most-negative value is its own complement.
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH - 1){1'b0}}};
  logic ovf_q, ovf_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      op_q       <= '0;
      cnt_q      <= '0;
      res_data_q <= '0;
`ifdef SCOMP_OVF_DETECT_EN
      ovf_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      res_data_q <= res_data_d;
`ifdef SCOMP_OVF_DETECT_EN
      ovf_q      <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_q;
`ifdef SCOMP_OVF_DETECT_EN
    ovf_d      = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d    = req_data;
          state_d = StLoad;
        end
      end
      StLoad: begin
        cnt_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        // Exit on the WIDTH-th shift edge; the counter never wraps.
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StCapt;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCapt: begin
        // The unit shifts again on this edge, so take the pre-edge value now.
        res_data_d = dp_out_sig;
`ifdef SCOMP_OVF_DETECT_EN
        ovf_d      = (op_q == MinNeg);
`endif
        state_d    = StResp;
      end
      StResp: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign req_ready   = rst_n && (state_q == StIdle);
  assign res_valid   = (state_q == StResp);
  assign res_data    = res_data_q;
  assign dp_load     = (state_q == StLoad);
  assign dp_load_sig = op_q;
`ifdef SCOMP_OVF_DETECT_EN
  assign res_ovf     = ovf_q;
`endif

`ifndef SYNTHESIS
  a_res_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (res_valid && !res_ready) |=> (res_valid && $stable(res_data)));
  a_load_pulse : assert property (@(posedge clk) disable iff (!rst_n)
    dp_load |=> !dp_load);
`endif

endmodule

// File: tb/tb_scompliment_ctrl.sv
// Scoreboard bench for scompliment_ctrl with a bit-serial complement unit model attached.
module tb_scompliment_ctrl;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_data;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic         dp_load;
  logic [W-1:0] dp_load_sig;
  logic [W-1:0] dp_out_sig;
`ifdef SCOMP_OVF_DETECT_EN
  logic         res_ovf;
`endif

  always #5 clk = ~clk;

  scompliment_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .dp_load    (dp_load),
    .dp_load_sig(dp_load_sig),
    .dp_out_sig (dp_out_sig)
`ifdef SCOMP_OVF_DETECT_EN
    ,
    .res_ovf    (res_ovf)
`endif
  );

  // Serial unit: LSB-first complement, result bits enter at the MSB.
  logic [W-1:0] sr = '0;
  logic         carry = 1'b0;
  always @(posedge clk) begin
    if (dp_load) begin
      sr    <= dp_load_sig;
      carry <= 1'b1;
    end else begin
      sr    <= {~sr[0] ^ carry, sr[W-1:1]};
      carry <= ~sr[0] & carry;
    end
  end
  assign dp_out_sig = sr;

  typedef struct {
    int data;
    int ovf;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_acc = -1;
  bit   chk_interval = 0;
  int   rr_mode = 0;
  bit   prev_valid = 0;
  bit   hs_pending = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Stimulus side: push the expected response as each operand is accepted.
  int   acc_op;
  exp_t acc_e;
  always @(negedge clk) begin
    if (rst_n && req_valid && req_ready) begin
      acc_op     = int'(req_data);
      acc_e.data = (MOD - acc_op) % MOD;
      acc_e.ovf  = (acc_op == MOD / 2) ? 1 : 0;
      exp_q.push_back(acc_e);
      acc_q.push_back(cyc + 1);
      if (chk_interval && last_acc >= 0) check("accept_interval", cyc + 1 - last_acc, W + 4);
      last_acc = cyc + 1;
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (hs_pending) begin
      check("req_ready_after_resp", int'(req_ready), 1);
      hs_pending = 0;
    end
    if (res_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", exp_q.size(), 1);
      end else begin
        if (!prev_valid) check("latency", cyc - acc_q[0], W + 2);
        check("res_data", int'(res_data), exp_q[0].data);
        if (res_ready) begin
`ifdef SCOMP_OVF_DETECT_EN
          check("res_ovf", int'(res_ovf), exp_q[0].ovf);
`endif
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
          hs_pending = 1;
        end
      end
    end
    prev_valid = res_valid;
  end

  // Sole driver of res_ready.
  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       res_ready = 1'b1;
        1:       res_ready = 1'($urandom_range(0, 1));
        default: res_ready = 1'b0;
      endcase
    end
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+#1; returns at posedge+#1 just after the accepting edge.
  task automatic send(input logic [W-1:0] op, input bit keep);
    int n = 0;
    req_valid = 1'b1;
    req_data  = op;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 100) begin
        check("accept_timeout", int'(req_ready), 1);
        break;
      end
    end
    align();
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    align();
  endtask

  logic [W-1:0] dir_ops [4] = '{4'b0000, 4'b0001, 4'b0111, 4'b1000};

  initial begin
    int n;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_data  = '0;

    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_dp_load", int'(dp_load), 0);
    check("rst_res_data", int'(res_data), 0);
    check("rst_dp_load_sig", int'(dp_load_sig), 0);
    align();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", int'(req_ready), 1);
    align();

    // First operand: single-cycle load pulse carrying the operand.
    send(4'b0011, 0);
    @(negedge clk);
    check("load_pulse_high", int'(dp_load), 1);
    check("load_sig", int'(dp_load_sig), 3);
    @(negedge clk);
    check("load_pulse_low", int'(dp_load), 0);
    wait_drain();

    foreach (dir_ops[i]) begin
      send(dir_ops[i], 0);
      wait_drain();
    end

    // Back-pressure for 20 cycles.
    rr_mode = 2;
    send(4'b0011, 0);
    n = 0;
    while (!res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid) check("resp_timeout", int'(res_valid), 1);
    repeat (20) begin
      @(negedge clk);
      check("hold_valid", int'(res_valid), 1);
    end
    rr_mode = 0;
    wait_drain();

    // Operand offered while busy is only taken once back in IDLE.
    chk_interval = 1;
    last_acc     = -1;
    send(4'b0011, 1);
    send(4'b0101, 0);
    wait_drain();
    chk_interval = 0;

    // Reset abort during SHIFT with cnt=2.
    send(4'b1010, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    align();
    rst_n = 1'b1;
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    check("abort_res_valid", int'(res_valid), 0);
    check("abort_dp_load", int'(dp_load), 0);
    check("abort_req_ready", int'(req_ready), 1);
    align();
    send(4'b0110, 0);
    wait_drain();

    // Exhaustive back-to-back sweep.
    chk_interval = 1;
    last_acc     = -1;
    for (int op = 0; op < MOD; op++) begin
      send(W'(op), op != MOD - 1);
    end
    wait_drain();
    chk_interval = 0;

    // Random operands, gaps and back-pressure.
    rr_mode = 1;
    for (int k = 0; k < 30; k++) begin
      send(W'($urandom), 0);
      repeat ($urandom_range(0, 3)) align();
    end
    wait_drain();
    rr_mode = 0;
    repeat (3) align();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scompliment_ctrl.md
Name: scompliment_ctrl

Overview:
- Sequencer for the bit-serial two's-complement unit (serialcompliment: shift register plus carry flop).
- Accepts an operand over a valid/ready request channel, pulses the unit's load, and counts WIDTH shift cycles.
- Captures the result into a holding register and presents it over a valid/ready response channel.
- Required because the unit shifts on every clock while load is low, so its output is valid for exactly one cycle.

Parameters:
- WIDTH, 4, operand width; must equal the width of the attached serial unit; WIDTH >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req_valid  input  1  operand available.
- req_ready  output  1  controller can accept an operand.
- req_data  input  WIDTH  operand.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- res_data  output  WIDTH  two's complement of the operand, modulo 2^WIDTH.
- dp_load  output  1  to the unit's load input.
- dp_load_sig  output  WIDTH  to the unit's load_sig input.
- dp_out_sig  input  WIDTH  from the unit's out_sig output.

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rst_n): on any rising edge with rst_n=0 the state goes to IDLE.
- Reset values:
  - req_ready=0 during reset, 1 from the first non-reset cycle.
  - res_valid=0, res_data=0, dp_load=0, dp_load_sig=0, shift counter=0, operand register=0.
- Serial unit contract:
  - A rising edge with dp_load=1 loads the operand and sets the carry flop.
  - Each rising edge with dp_load=0 shifts once.
  - After exactly WIDTH shift edges, dp_out_sig holds the result.
- States:
  - IDLE: req_ready=1, dp_load=0. On an edge with req_valid=1, latch req_data into op_q and go to LOAD. Otherwise stay.
  - LOAD: one cycle. dp_load=1, dp_load_sig=op_q, req_ready=0. Next state SHIFT, cnt=0.
  - SHIFT: dp_load=0, dp_load_sig=op_q (don't-care, but held stable). cnt increments each edge. When cnt==WIDTH-1, go to CAPT.
  - CAPT: one cycle. On the edge, res_data <= dp_out_sig, then go to RESP. The unit shifts again on this edge; the pre-edge value is the one captured.
  - RESP: res_valid=1; res_data stable and unchanged while res_valid=1. On an edge with res_ready=1, clear res_valid and go to IDLE.
- Latency: res_valid rises WIDTH+2 edges after the accepting edge (6 for WIDTH=4).
- Throughput: one operation per WIDTH+4 cycles when res_ready=1.
- req_ready is 1 only in IDLE. req_valid in any other state is ignored, and the operand is not latched.
- res_ready while res_valid=0 is ignored.
- Back-pressure: RESP holds indefinitely. The unit keeps shifting meanwhile, with no effect on res_data.
- Arithmetic: res_data = (~op + 1) mod 2^WIDTH, so 0 maps to 0.
- Reset mid-operation (any state): abort and return to IDLE.
  - res_valid=0, dp_load=0.
  - No result is produced for the aborted operand.
  - The unit's stale state is harmless because the next LOAD reinitialises it.
- Counter width is $clog2(WIDTH). No wrap-around occurs beyond WIDTH-1.

Optional Feature:
- Macro: SCOMP_OVF_DETECT_EN.
- When defined:
  - Extra output res_ovf, 1 bit.
  - Captured in CAPT as 1 when op_q == {1'b1, (WIDTH-1){1'b0}} (most-negative value; its complement is itself). Otherwise 0.
  - Valid with res_valid; reset value 0; cleared on reset abort.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Reset, then req_data=4'b0011 with req_valid=1 and res_ready=1 -> dp_load high for exactly one cycle; res_valid rises 6 edges after accept with res_data=4'b1101; req_ready back to 1 the cycle after the response handshake.
- Operands 4'b0000, 4'b0001, 4'b0111 -> results 4'b0000, 4'b1111, 4'b1001 respectively. With SCOMP_OVF_DETECT_EN, 4'b1000 -> 4'b1000 with res_ovf=1, and res_ovf=0 for the others.
- res_ready held 0 for 20 cycles after res_valid -> res_data stays 4'b1101 and res_valid stays 1 throughout; completes on the first res_ready=1 edge.
- req_valid=1 with req_data=4'b0101 asserted during SHIFT -> ignored. The in-flight result is unaffected; 0101 is accepted only once the controller is back in IDLE, giving 4'b1011.
- rst_n=0 for one edge during SHIFT (cnt=2) -> next cycle IDLE, res_valid=0, dp_load=0. A following operand 4'b0110 gives 4'b1010 with normal latency.
- Exhaustive sweep of all 16 operands, back-to-back with res_ready=1 -> each result equals (~op+1)&4'hF; the accept-to-accept interval is 8 cycles.
